subleq_cpu_param: RTL and testbench

Parametrised next-generation SUBLEQ core. Executes `M[b] = M[b] - M[a]; if result <= 0 then pc = c else pc = pc + 3` over a single shared word-addressed memory port. New relative to the fixed 64-bit core:
- Configurable data and address width.
- A `mem_ready` stall handshake.
- Run/pause control at instruction boundaries.
- Halt on negative branch target.
- Retired-instruction counter.

---
 rtl/subleq_cpu_param_if.sv | 22 ++
 rtl/subleq_cpu_param.sv | 139 +++++++++++++
 tb/tb_subleq_cpu_param.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/subleq_cpu_param_if.sv
// Word-addressed memory bus between the SUBLEQ core (master) and its memory (slave).
// mem_op: 00 read, 01 write, 11 idle; a request completes in a cycle with mem_ready=1.
interface subleq_cpu_param_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 64
) ();
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        mem_op;
  logic              mem_ready;

  modport master (
    output mem_addr, mem_wdata, mem_op,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_op,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/subleq_cpu_param.sv
// Parametrised SUBLEQ core: M[b] -= M[a]; branch to c when the result is <= 0.
// One sequential access per state over a stallable shared memory port.
module subleq_cpu_param #(
  parameter int unsigned       DATA_W      = 64,
  parameter int unsigned       ADDR_W      = 64,
  parameter logic [ADDR_W-1:0] PC_RESET    = '0,
  parameter bit                HALT_ON_NEG = 1'b1,
  parameter int unsigned       CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  subleq_cpu_param_if.master     mem,
  output logic                   halted,
  output logic [CNT_W-1:0]       retired,
  output logic [ADDR_W-1:0]      pc_out
);

  typedef enum logic [2:0] {
    DISPATCH,
    RD_A,
    RD_B,
    RD_MA,
    RD_MB,
    WR,
    RD_C
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_IDLE  = 2'b11;

  state_t state;
  state_t state_nxt;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] a;
  logic [ADDR_W-1:0] b;
  logic [DATA_W-1:0] va;
  logic [DATA_W-1:0] res;
  logic              res_le0;
  logic              neg_target;

  assign res_le0    = res[DATA_W-1] | (res == '0);
  assign neg_target = HALT_ON_NEG && mem.mem_rdata[DATA_W-1];
  assign pc_out     = pc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= DISPATCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DISPATCH: if (!halted && run) state_nxt = RD_A;
      RD_A:     if (mem.mem_ready) state_nxt = RD_B;
      RD_B:     if (mem.mem_ready) state_nxt = RD_MA;
      RD_MA:    if (mem.mem_ready) state_nxt = RD_MB;
      RD_MB:    if (mem.mem_ready) state_nxt = WR;
      WR:       if (mem.mem_ready) state_nxt = res_le0 ? RD_C : DISPATCH;
      RD_C:     if (mem.mem_ready) state_nxt = DISPATCH;
      default:  state_nxt = DISPATCH;
    endcase
  end

  // Bus outputs are a pure decode of state and registers, never of mem_rdata/mem_ready.
  always_comb begin
    mem.mem_op    = OP_IDLE;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    case (state)
      RD_A: begin
        mem.mem_op   = OP_READ;
        mem.mem_addr = pc;
      end
      RD_B: begin
        mem.mem_op   = OP_READ;
        mem.mem_addr = pc + ADDR_W'(1);
      end
      RD_MA: begin
        mem.mem_op   = OP_READ;
        mem.mem_addr = a;
      end
      RD_MB: begin
        mem.mem_op   = OP_READ;
        mem.mem_addr = b;
      end
      WR: begin
        mem.mem_op    = OP_WRITE;
        mem.mem_addr  = b;
        mem.mem_wdata = res;
      end
      RD_C: begin
        mem.mem_op   = OP_READ;
        mem.mem_addr = pc + ADDR_W'(2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc      <= PC_RESET;
      a       <= '0;
      b       <= '0;
      va      <= '0;
      res     <= '0;
      retired <= '0;
      halted  <= 1'b0;
    end else if (mem.mem_ready) begin
      case (state)
        RD_A:  a   <= mem.mem_rdata[ADDR_W-1:0];
        RD_B:  b   <= mem.mem_rdata[ADDR_W-1:0];
        RD_MA: va  <= mem.mem_rdata;
        RD_MB: res <= mem.mem_rdata - va;
        WR: begin
          if (!res_le0) begin
            pc      <= pc + ADDR_W'(3);
            retired <= retired + CNT_W'(1);
          end
        end
        RD_C: begin
          retired <= retired + CNT_W'(1);
          if (neg_target) begin
            halted <= 1'b1;
          end else begin
            pc <= mem.mem_rdata[ADDR_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_subleq_cpu_param.sv
// Directed bench for subleq_cpu_param: a default-width core and an 8-bit-address core
// each paired with a small behavioural memory.
module tb_subleq_cpu_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- default core: 64-bit data / address ----------------
  logic        rst0, run0, ready0, halted0;
  logic [31:0] retired0;
  logic [63:0] pc0;
  logic [63:0] mem0 [0:63];
  int          wcount0 = 0;
  logic        pk0_en;
  logic [5:0]  pk0_addr;
  logic [63:0] pk0_data;

  subleq_cpu_param_if #(.DATA_W(64), .ADDR_W(64)) bus0 ();
  assign bus0.mem_rdata = mem0[bus0.mem_addr[5:0]];
  assign bus0.mem_ready = ready0;

  subleq_cpu_param #(
    .DATA_W(64), .ADDR_W(64), .PC_RESET(64'd0), .HALT_ON_NEG(1'b1), .CNT_W(32)
  ) dut0 (
    .clk(clk), .reset(rst0), .run(run0), .mem(bus0),
    .halted(halted0), .retired(retired0), .pc_out(pc0)
  );

  always @(posedge clk) begin
    if (pk0_en) begin
      mem0[pk0_addr] <= pk0_data;
    end else if (bus0.mem_op == 2'b01 && bus0.mem_ready) begin
      mem0[bus0.mem_addr[5:0]] <= bus0.mem_wdata;
      wcount0 <= wcount0 + 1;
    end
  end

  // ---------------- narrow core: 16-bit data / 8-bit address ----------------
  logic        rst1, run1, ready1, halted1;
  logic [7:0]  retired1;
  logic [7:0]  pc1;
  logic [15:0] mem1 [0:255];
  logic        pk1_en;
  logic [7:0]  pk1_addr;
  logic [15:0] pk1_data;

  subleq_cpu_param_if #(.DATA_W(16), .ADDR_W(8)) bus1 ();
  assign bus1.mem_rdata = mem1[bus1.mem_addr];
  assign bus1.mem_ready = ready1;

  subleq_cpu_param #(
    .DATA_W(16), .ADDR_W(8), .PC_RESET(8'd254), .HALT_ON_NEG(1'b1), .CNT_W(8)
  ) dut1 (
    .clk(clk), .reset(rst1), .run(run1), .mem(bus1),
    .halted(halted1), .retired(retired1), .pc_out(pc1)
  );

  always @(posedge clk) begin
    if (pk1_en) begin
      mem1[pk1_addr] <= pk1_data;
    end else if (bus1.mem_op == 2'b01 && bus1.mem_ready) begin
      mem1[bus1.mem_addr] <= bus1.mem_wdata;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic poke0(input logic [5:0] addr, input logic [63:0] data);
    pk0_en = 1'b1; pk0_addr = addr; pk0_data = data;
    step(1);
    pk0_en = 1'b0;
  endtask

  task automatic poke1(input logic [7:0] addr, input logic [15:0] data);
    pk1_en = 1'b1; pk1_addr = addr; pk1_data = data;
    step(1);
    pk1_en = 1'b0;
  endtask

  // {3,4,6}, M[3]=5, M[4]=7; second instruction at 3 is {5,2,1} writing 6-1=5 to addr 2
  task automatic load_prog1();
    poke0(6'd0, 64'd3);
    poke0(6'd1, 64'd4);
    poke0(6'd2, 64'd6);
    poke0(6'd3, 64'd5);
    poke0(6'd4, 64'd7);
    poke0(6'd5, 64'd1);
  endtask

  int idle_bad;
  int w_before;

  initial begin
    rst0 = 1'b0; run0 = 1'b0; ready0 = 1'b1; pk0_en = 1'b0; pk0_addr = '0; pk0_data = '0;
    rst1 = 1'b0; run1 = 1'b0; ready1 = 1'b1; pk1_en = 1'b0; pk1_addr = '0; pk1_data = '0;
    step(2);

    check("rst_op",      {62'd0, bus0.mem_op}, 64'd3);
    check("rst_addr",    bus0.mem_addr, 64'd0);
    check("rst_wdata",   bus0.mem_wdata, 64'd0);
    check("rst_pc",      pc0, 64'd0);
    check("rst_retired", {32'd0, retired0}, 64'd0);
    check("rst_halted",  {63'd0, halted0}, 64'd0);

    // Scenario 1 + run drop in RD_B + reset during stalled WR
    load_prog1();
    run0 = 1'b1; rst0 = 1'b1;
    step(2);
    check("s1_rdb_addr", bus0.mem_addr, 64'd1);
    run0 = 1'b0;
    step(3);
    check("s1_wr_op",    {62'd0, bus0.mem_op}, 64'd1);
    check("s1_wr_addr",  bus0.mem_addr, 64'd4);
    check("s1_wr_data",  bus0.mem_wdata, 64'd2);
    check("s1_ret_5",    {32'd0, retired0}, 64'd0);
    step(1);
    check("s1_ret_6",    {32'd0, retired0}, 64'd1);
    check("s1_pc",       pc0, 64'd3);
    check("s1_mem4",     mem0[4], 64'd2);
    step(4);
    check("s5_idle_op",  {62'd0, bus0.mem_op}, 64'd3);
    check("s5_idle_ret", {32'd0, retired0}, 64'd1);
    run0 = 1'b1;
    step(1);
    check("s5_fetch_op",   {62'd0, bus0.mem_op}, 64'd0);
    check("s5_fetch_addr", bus0.mem_addr, 64'd3);
    step(4);
    check("s6_wr_addr",  bus0.mem_addr, 64'd2);
    check("s6_wr_data",  bus0.mem_wdata, 64'd5);
    ready0 = 1'b0;
    step(1);
    check("s6_stall_op", {62'd0, bus0.mem_op}, 64'd1);
    w_before = wcount0;
    rst0 = 1'b0;
    step(1);
    check("s6_rst_op",      {62'd0, bus0.mem_op}, 64'd3);
    check("s6_rst_addr",    bus0.mem_addr, 64'd0);
    check("s6_rst_wdata",   bus0.mem_wdata, 64'd0);
    check("s6_rst_pc",      pc0, 64'd0);
    check("s6_rst_retired", {32'd0, retired0}, 64'd0);
    check("s6_no_write",    mem0[2], 64'd6);
    check("s6_wcount",      64'(wcount0), 64'(w_before));
    ready0 = 1'b1; run0 = 1'b0;

    // Scenario 2: result exactly 0 takes the branch
    poke0(6'd4, 64'd5);
    run0 = 1'b1; rst0 = 1'b1;
    step(2);
    run0 = 1'b0;
    step(4);
    check("s2_rdc_op",   {62'd0, bus0.mem_op}, 64'd0);
    check("s2_rdc_addr", bus0.mem_addr, 64'd2);
    check("s2_mem4",     mem0[4], 64'd0);
    check("s2_ret_6",    {32'd0, retired0}, 64'd0);
    step(1);
    check("s2_ret_7",    {32'd0, retired0}, 64'd1);
    check("s2_pc",       pc0, 64'd6);

    // Scenario 3: aliasing a==b, negative target halts
    rst0 = 1'b0;
    step(1);
    poke0(6'd0, 64'd3);
    poke0(6'd1, 64'd3);
    poke0(6'd2, '1);
    poke0(6'd3, 64'd5);
    run0 = 1'b1; rst0 = 1'b1;
    step(6);
    check("s3_mem3",    mem0[3], 64'd0);
    step(1);
    check("s3_halted",  {63'd0, halted0}, 64'd1);
    check("s3_pc",      pc0, 64'd0);
    check("s3_retired", {32'd0, retired0}, 64'd1);
    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus0.mem_op != 2'b11) idle_bad++;
    end
    check("s3_idle_cycles", 64'(idle_bad), 64'd0);
    check("s3_still_halt",  {63'd0, halted0}, 64'd1);

    // Scenario 4: 3-cycle stalls in RD_MA and WR
    rst0 = 1'b0; run0 = 1'b0;
    step(1);
    load_prog1();
    check("s4_rst_unhalt", {63'd0, halted0}, 64'd0);
    run0 = 1'b1; rst0 = 1'b1;
    step(2);
    run0 = 1'b0;
    step(1);
    ready0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("s4_ma_op",   {62'd0, bus0.mem_op}, 64'd0);
      check("s4_ma_addr", bus0.mem_addr, 64'd3);
    end
    ready0 = 1'b1;
    step(2);
    ready0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("s4_wr_op",   {62'd0, bus0.mem_op}, 64'd1);
      check("s4_wr_addr", bus0.mem_addr, 64'd4);
      check("s4_wr_data", bus0.mem_wdata, 64'd2);
      check("s4_wr_hold", mem0[4], 64'd7);
    end
    check("s4_ret_11", {32'd0, retired0}, 64'd0);
    ready0 = 1'b1;
    step(1);
    check("s4_ret_12", {32'd0, retired0}, 64'd1);
    check("s4_pc",     pc0, 64'd3);
    check("s4_mem4",   mem0[4], 64'd2);

    // Scenario 6b: 8-bit address wrap from pc=254
    poke1(8'd254, 16'd10);
    poke1(8'd255, 16'd11);
    poke1(8'd0,   16'd20);
    poke1(8'd10,  16'd1);
    poke1(8'd11,  16'd5);
    check("w_rst_pc", {56'd0, pc1}, 64'd254);
    check("w_rst_op", {62'd0, bus1.mem_op}, 64'd3);
    run1 = 1'b1; rst1 = 1'b1;
    step(1);
    check("w_rda_addr", {56'd0, bus1.mem_addr}, 64'd254);
    step(1);
    check("w_rdb_addr", {56'd0, bus1.mem_addr}, 64'd255);
    run1 = 1'b0;
    step(4);
    check("w_pc",      {56'd0, pc1}, 64'd1);
    check("w_retired", {56'd0, retired1}, 64'd1);
    check("w_mem11",   {48'd0, mem1[11]}, 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
